// File: rtl/mmio_port_controller.sv
// mmio_port_controller: MMIO stage with PortOut register, synchronised PortIn, output FIFO and status register.
// Optional build macro MMIO_PUSH_COUNTER_EN adds a saturating 16-bit accepted-push counter in STATUS[31:16].
module mmio_port_controller #(
  parameter int          DATA_WIDTH  = 32,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [31:0] OUT_ADDR    = 32'h1001_0024,
  parameter logic [31:0] IN_ADDR     = 32'h1001_0028,
  parameter logic [31:0] STATUS_ADDR = 32'h1001_002C
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           Address,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  MemWrite,
  input  logic                  MemRead,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic                  Hit,
  input  logic [7:0]            PortIn,
  output logic [DATA_WIDTH-1:0] PortOut,
  output logic [DATA_WIDTH-1:0] OutData,
  output logic                  OutValid,
  input  logic                  OutReady
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_rd, r_wr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_overflow, r_in_changed;
  logic [7:0]            r_sync1, r_sync2, r_prev;
  logic                  w_hit_out, w_hit_in, w_hit_st;
  logic                  w_empty, w_full, w_push_req, w_push, w_pop;
  logic                  w_ovf_set, w_chg_set, w_st_rd;
  logic [15:0]           w_push_cnt;
  logic [31:0]           w_status;

  assign w_hit_out  = Address == OUT_ADDR;
  assign w_hit_in   = Address == IN_ADDR;
  assign w_hit_st   = Address == STATUS_ADDR;
  assign Hit        = w_hit_out | w_hit_in | w_hit_st;
  assign w_empty    = r_count == '0;
  assign w_full     = r_count == CNT_W'(FIFO_DEPTH);
  assign w_pop      = !w_empty && OutReady;
  assign w_push_req = MemWrite && w_hit_out;
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_ovf_set  = w_push_req && w_full && !w_pop;
  assign w_chg_set  = r_sync2 != r_prev;
  assign w_st_rd    = MemRead && w_hit_st;
  assign OutValid   = !w_empty;
  assign OutData    = w_empty ? '0 : r_mem[r_rd];
  assign w_status   = {w_push_cnt, 3'b0, 5'(r_count), 4'b0, r_in_changed, r_overflow, w_full, w_empty};

  // Load data mux; returns pre-write state when a store happens in the same cycle
  always_comb begin
    ReadData = '0;
    if (MemRead)
      ReadData = w_hit_out ? PortOut :
                 w_hit_in  ? DATA_WIDTH'(r_sync2) :
                 w_hit_st  ? DATA_WIDTH'(w_status) : '0;
  end

  // FIFO storage; contents need no reset since count gates visibility
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= WriteData;

  // PortOut, FIFO pointers/count and sticky flags; set beats read-to-clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      PortOut      <= '0;
      r_rd         <= '0;
      r_wr         <= '0;
      r_count      <= '0;
      r_overflow   <= 1'b0;
      r_in_changed <= 1'b0;
    end else begin
      if (w_push_req) PortOut <= WriteData;
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_count      <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      r_overflow   <= w_ovf_set | (r_overflow & ~w_st_rd);
      r_in_changed <= w_chg_set | (r_in_changed & ~w_st_rd);
    end
  end

  // Two-flop synchroniser plus a previous-value stage for change detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= PortIn;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

`ifdef MMIO_PUSH_COUNTER_EN
  logic [15:0] r_push_cnt;
  assign w_push_cnt = r_push_cnt;
  // Saturating count of accepted FIFO pushes, cleared only by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_push_cnt <= '0;
    else if (w_push && r_push_cnt != 16'hFFFF) r_push_cnt <= r_push_cnt + 16'd1;
  end
`else
  assign w_push_cnt = '0;
`endif

endmodule

// File: tb/tb_mmio_port_controller.sv
// tb_mmio_port_controller: directed self-checking bench for mmio_port_controller.
module tb_mmio_port_controller;
  localparam logic [31:0] OUT_A = 32'h1001_0024;
  localparam logic [31:0] IN_A  = 32'h1001_0028;
  localparam logic [31:0] ST_A  = 32'h1001_002C;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] Address = '0, WriteData = '0;
  logic        MemWrite = 1'b0, MemRead = 1'b0, OutReady = 1'b0;
  logic [7:0]  PortIn = '0;
  logic [31:0] ReadData, PortOut, OutData;
  logic        Hit, OutValid;
  int          n_cmp = 0, n_bad = 0, pushes = 0;
  logic [31:0] drain_exp [4] = '{32'd2, 32'd3, 32'd4, 32'd6};

  mmio_port_controller dut (
    .clk(clk), .reset(reset), .Address(Address), .WriteData(WriteData),
    .MemWrite(MemWrite), .MemRead(MemRead), .ReadData(ReadData), .Hit(Hit),
    .PortIn(PortIn), .PortOut(PortOut), .OutData(OutData), .OutValid(OutValid),
    .OutReady(OutReady)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] st(input logic [31:0] b);
`ifdef MMIO_PUSH_COUNTER_EN
    return b | {pushes[15:0], 16'h0};
`else
    return b;
`endif
  endfunction

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    Address = a; WriteData = d; MemWrite = 1'b1;
    @(negedge clk);
    MemWrite = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    Address = a; MemRead = 1'b1;
    #1 chk(tag, ReadData, exp);
    @(negedge clk);
    MemRead = 1'b0;
  endtask

  initial begin
    #1;
    chk("rst_portout", PortOut, 32'h0);
    chk("rst_valid", {31'b0, OutValid}, 32'h0);
    chk("rst_outdata", OutData, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    rd_chk("rst_status", ST_A, st(32'h1));
    store(OUT_A, 32'hA5); pushes++;
    chk("a5_portout", PortOut, 32'hA5);
    chk("a5_valid", {31'b0, OutValid}, 32'h1);
    chk("a5_outdata", OutData, 32'hA5);
    rd_chk("a5_status", ST_A, st(32'h100));
    OutReady = 1'b1;
    @(negedge clk);
    OutReady = 1'b0;
    chk("a5_drained", {31'b0, OutValid}, 32'h0);
    store(IN_A, 32'hDEAD);
    chk("in_store_ignored", PortOut, 32'hA5);
    rd_chk("in_store_status", ST_A, st(32'h1));
    Address = OUT_A + 32'd1; MemRead = 1'b1;
    #1 chk("nohit_hit", {31'b0, Hit}, 32'h0);
    chk("nohit_data", ReadData, 32'h0);
    @(negedge clk);
    MemRead = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      store(OUT_A, i);
      if (i <= 4) pushes++;
    end
    chk("ovf_portout", PortOut, 32'h5);
    chk("ovf_head", OutData, 32'h1);
    rd_chk("ovf_status", ST_A, st(32'h406));
    rd_chk("ovf_cleared", ST_A, st(32'h402));
    Address = OUT_A; WriteData = 32'h6; MemWrite = 1'b1; MemRead = 1'b1; OutReady = 1'b1;
    #1 chk("rw_old_data", ReadData, 32'h5);
    @(negedge clk);
    MemWrite = 1'b0; MemRead = 1'b0; OutReady = 1'b0; pushes++;
    chk("pp_portout", PortOut, 32'h6);
    rd_chk("pp_status", ST_A, st(32'h402));
    OutReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk($sformatf("drain_%0d", i), OutData, drain_exp[i]);
      @(negedge clk);
    end
    OutReady = 1'b0;
    chk("drain_empty", {31'b0, OutValid}, 32'h0);
    PortIn = 8'h3C; Address = IN_A; MemRead = 1'b1;
    #1 chk("pin_c0", ReadData, 32'h0);
    @(negedge clk);
    #1 chk("pin_c1", ReadData, 32'h0);
    @(negedge clk);
    #1 chk("pin_c2", ReadData, 32'h3C);
    @(negedge clk);
    Address = ST_A;
    #1 chk("pin_changed", ReadData, st(32'h9));
    @(negedge clk);
    #1 chk("pin_chg_clear", ReadData, st(32'h1));
    @(negedge clk);
    MemRead = 1'b0;
    for (int i = 7; i <= 9; i++) begin
      store(OUT_A, i);
      pushes++;
    end
    OutReady = 1'b1;
    #2 reset = 1'b0;
    #1 chk("arst_valid", {31'b0, OutValid}, 32'h0);
    chk("arst_portout", PortOut, 32'h0);
    chk("arst_outdata", OutData, 32'h0);
    @(negedge clk);
    OutReady = 1'b0; reset = 1'b1; pushes = 0;
    @(negedge clk);
    rd_chk("arst_status", ST_A, st(32'h1));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mmio_port_controller.md
Name: mmio_port_controller

Overview:
- Memory-mapped I/O stage directly downstream of the single-cycle MIPS core's data-side bus.
- Consumes the core's ALU result as the address, plus register-file read data 2 as write data and the MemWrite/MemRead strobes.
- Owns the PortOut register, a synchronised PortIn, and a small output FIFO that a downstream consumer (display/serial driver) drains over a valid/ready handshake.
- Returns read data and a hit flag to the top-level MemtoReg mux.

Parameters:
- DATA_WIDTH, 32, width of bus data, PortOut and FIFO entries.
- FIFO_DEPTH, 4, output FIFO entries; power of two, 2..16.
- OUT_ADDR, 32'h1001_0024, PortOut/FIFO push register address.
- IN_ADDR, 32'h1001_0028, PortIn read address.
- STATUS_ADDR, 32'h1001_002C, status register address.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- Address  input  32  byte address from the core's ALU result.
- WriteData  input  DATA_WIDTH  store data (register-file read data 2).
- MemWrite  input  1  store strobe.
- MemRead  input  1  load strobe.
- ReadData  output  DATA_WIDTH  load data; combinational.
- Hit  output  1  Address equals one of the three MMIO addresses; combinational.
- PortIn  input  8  asynchronous external input.
- PortOut  output  DATA_WIDTH  registered output port.
- OutData  output  DATA_WIDTH  FIFO head.
- OutValid  output  1  FIFO non-empty.
- OutReady  input  1  consumer accepts the head this cycle.

Behaviour:
- Reset is asynchronous and active-low. While reset=0: PortOut=0, FIFO empty, count=0, OutValid=0, OutData=0, overflow=0, in_changed=0, sync stages=0.
- Address decode: full 32-bit equality compare; no partial or byte decode.
- Store to OUT_ADDR (MemWrite=1):
  - At the next rising edge, PortOut<=WriteData (1-cycle latency).
  - The same value is pushed into the FIFO if it is not full.
  - If the FIFO is full and there is no simultaneous pop, the push is dropped, PortOut still updates, and the overflow flag is set (sticky).
- Stores to IN_ADDR or STATUS_ADDR are ignored.
- Pop: occurs on a rising edge with OutValid&&OutReady; the head advances.
- Simultaneous push and pop:
  - When full: both are performed, count is unchanged, no overflow.
  - When empty: push only. OutValid rises the cycle after the push; there is no bypass.
- OutData: holds the head entry while OutValid=1; it is don't-care while empty (drive 0).
- FIFO storage is a circular buffer with rd/wr pointers that wrap modulo FIFO_DEPTH. Count is tracked separately (0..FIFO_DEPTH).
- PortIn synchronisation:
  - Two-flop synchroniser, then a third "previous" register.
  - in_changed sets (sticky) when the synchronised value differs from the previous value.
  - PortIn reaches IN_ADDR readback 2 cycles after the input changes.
- Reads (MemRead=1 and Hit): ReadData is combinational. Otherwise ReadData=0.
  - IN_ADDR returns zero-extended synchronised PortIn.
  - OUT_ADDR returns PortOut.
  - STATUS_ADDR returns:
    - bit0 empty
    - bit1 full
    - bit2 overflow
    - bit3 in_changed
    - bits[12:8] count
    - all other bits 0 unless the optional feature is enabled.
- Read-to-clear: a STATUS read clears overflow and in_changed at the next edge. If a new set event occurs in the same cycle, set wins.
- MemRead and MemWrite both high: the write takes effect; the read returns pre-write values.
- Reset asserted mid-operation: FIFO contents are discarded immediately and OutValid drops asynchronously.

Optional Feature:
- Macro: MMIO_PUSH_COUNTER_EN.
- Defined: a 16-bit counter of accepted FIFO pushes.
  - Saturates at 16'hFFFF.
  - Readable in STATUS bits[31:16].
  - Cleared by reset only; not by status reads.
- Not defined: no counter logic; STATUS bits[31:16] read 0.

Test Plan:
- Reset then store 32'hA5 to OUT_ADDR: the next cycle PortOut=32'hA5, OutValid=1, OutData=32'hA5, STATUS reads 32'h0000_0100 (count=1).
- OutReady=0, store 5 values 1..5 with FIFO_DEPTH=4: FIFO holds 1..4. Then:
  - STATUS bit1=1, bit2=1, PortOut=5.
  - A second STATUS read returns overflow=0.
  - Drain with OutReady=1 yields 1,2,3,4, after which OutValid=0.
- With the FIFO full, store 32'h6 while OutReady=1: pop of the head and push of 6 occur in the same cycle, count stays 4, overflow stays 0, and 6 emerges last.
- PortIn 8'h00->8'h3C: IN_ADDR reads 0 for 2 cycles, then 32'h3C; STATUS bit3=1 until read, then 0.
- Assert reset low mid-drain with 3 entries queued: OutValid=0 and PortOut=0 without a clock edge; after release, STATUS=32'h0000_0001.
- With MMIO_PUSH_COUNTER_EN defined, after the FIFO-overflow scenario: STATUS[31:16]=4 (the dropped push is not counted).
